lbist_tpg: RTL and testbench

LFSR-based test pattern generator for the LBIST datapath. It drives pseudo-random patterns into the circuit under test. It sits at the receiving end of the BIST controller's TPG_RESET and FIL_INC outputs, and returns TPG_END to the controller. Each run uses one seed from a derived seed sequence; the controller re-runs the current seed or advances to the next one.

---
 rtl/lbist_tpg.sv | 114 +++++++++++
 tb/tb_lbist_tpg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_tpg.sv
// LFSR test pattern generator: one Fibonacci LFSR run per derived seed, with
// RUN/HOLD/DONE sequencing. Optional stall input is enabled by TPG_HOLD_EN.
module lbist_tpg #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] POLY       = 8'hB8,
   parameter int               PATTERNS   = 16,
   parameter int               SEED_COUNT = 4,
   parameter logic [WIDTH-1:0] SEED_BASE  = 8'h01,
   parameter logic [WIDTH-1:0] SEED_STEP  = 8'h35,
   localparam int              IDX_W      = (SEED_COUNT > 1) ? $clog2(SEED_COUNT) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tpg_reset,
   input  logic             seed_inc,
`ifdef TPG_HOLD_EN
   input  logic             hold,
`endif
   output logic [WIDTH-1:0] pattern,
   output logic             pattern_valid,
   output logic             tpg_end,
   output logic [IDX_W-1:0] seed_idx,
   output logic             all_done
);

   localparam int             CNT_W    = $clog2(PATTERNS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEED_COUNT - 1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] seed_idx_q, seed_idx_d;
   logic             stall;
   logic             fb;
   logic [WIDTH-1:0] lfsr_step;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [WIDTH-1:0] seed_of(input logic [IDX_W-1:0] idx);
      logic [WIDTH-1:0] idx_w;
      logic [WIDTH-1:0] s;
      idx_w = WIDTH'(idx);
      s     = SEED_BASE ^ (idx_w * SEED_STEP);
      if (s == '0) begin
         s = WIDTH'(1);
      end
      return s;
   endfunction

`ifdef TPG_HOLD_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   assign fb        = ^(lfsr_q & POLY);
   assign lfsr_step = {lfsr_q[WIDTH-2:0], fb};

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      cnt_d      = cnt_q;
      seed_idx_d = seed_idx_q;
      if (state_q != ST_DONE && seed_inc) begin
         if (seed_idx_q < IDX_LAST) begin
            seed_idx_d = seed_idx_q + 1'b1;
            lfsr_d     = seed_of(seed_idx_q + 1'b1);
            cnt_d      = '0;
            state_d    = ST_RUN;
         end else begin
            state_d = ST_DONE;
         end
      end else if (state_q != ST_DONE && tpg_reset) begin
         lfsr_d  = seed_of(seed_idx_q);
         cnt_d   = '0;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN && !stall) begin
         // The last pattern stays on the bus while parked in HOLD.
         if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
         end else begin
            lfsr_d = lfsr_step;
            cnt_d  = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         lfsr_q     <= seed_of('0);
         cnt_q      <= '0;
         seed_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
         seed_idx_q <= seed_idx_d;
      end
   end

   assign pattern       = lfsr_q;
   assign pattern_valid = (state_q == ST_RUN) && !stall;
   assign tpg_end       = (state_q == ST_RUN) && (cnt_q == CNT_LAST) && !stall;
   assign seed_idx      = seed_idx_q;
   assign all_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lbist_tpg.sv
// Directed bench for lbist_tpg with default parameters; the hold scenario
// is compiled only when TPG_HOLD_EN is defined.
module tb_lbist_tpg;

   logic       clk;
   logic       rst;
   logic       tpg_reset;
   logic       seed_inc;
   logic       hold;
   logic [7:0] pattern;
   logic       pattern_valid;
   logic       tpg_end;
   logic [1:0] seed_idx;
   logic       all_done;

   int checks;
   int errors;

   logic [7:0] exp_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                                8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};
   logic [7:0] exp_start [4] = '{8'h01, 8'h34, 8'h6B, 8'h9E};

   lbist_tpg dut (
      .clk           (clk),
      .rst           (rst),
      .tpg_reset     (tpg_reset),
      .seed_inc      (seed_inc),
`ifdef TPG_HOLD_EN
      .hold          (hold),
`endif
      .pattern       (pattern),
      .pattern_valid (pattern_valid),
      .tpg_end       (tpg_end),
      .seed_idx      (seed_idx),
      .all_done      (all_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Expects the first pattern of a seed-0 run on the bus now; walks all 16.
   task automatic run_seed0(input string tag);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (pattern !== exp_seq[i] || pattern_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s pat[%0d] got %h/v%b want %h/v1", tag, i, pattern, pattern_valid, exp_seq[i]);
         end
         checks++;
         if (tpg_end !== (i == 15)) begin
            errors++;
            $display("FAIL %s tpg_end[%0d] got %b want %b", tag, i, tpg_end, (i == 15));
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pattern !== 8'h25 || pattern_valid !== 1'b0 || tpg_end !== 1'b0) begin
            errors++;
            $display("FAIL %s hold[%0d] got %h/v%b/e%b want 25/v0/e0", tag, i, pattern, pattern_valid, tpg_end);
         end
         tick();
      end
      $display("run %s done", tag);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (pattern !== 8'h01 || pattern_valid !== 1'b1 || tpg_end !== 1'b0
          || seed_idx !== 2'd0 || all_done !== 1'b0) begin
         errors++;
         $display("FAIL reset got pat=%h v=%b e=%b idx=%0d done=%b want 01 1 0 0 0",
                  pattern, pattern_valid, tpg_end, seed_idx, all_done);
      end
      $display("test_reset pattern=%h", pattern);
   endtask

   task automatic test_free_run();
      run_seed0("free_run");
   endtask

   task automatic test_tpg_reset();
      tpg_reset = 1'b1;
      tick();
      tpg_reset = 1'b0;
      checks++;
      if (seed_idx !== 2'd0) begin
         errors++;
         $display("FAIL tpg_reset idx got %0d want 0", seed_idx);
      end
      run_seed0("tpg_reset");
   endtask

   task automatic test_seed_inc();
      bit seen;
      for (int k = 1; k < 4; k++) begin
         seed_inc = 1'b1;
         tick();
         seed_inc = 1'b0;
         checks++;
         if (pattern !== exp_start[k] || seed_idx !== 2'(k) || pattern_valid !== 1'b1) begin
            errors++;
            $display("FAIL seed_inc%0d got pat=%h idx=%0d v=%b want %h %0d 1",
                     k, pattern, seed_idx, pattern_valid, exp_start[k], k);
         end
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            if (tpg_end === 1'b1) seen = 1'b1;
            tick();
         end
         checks++;
         if (!seen || pattern_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_inc%0d_end seen=%b v=%b want 1 0", k, seen, pattern_valid);
         end
         $display("seed %0d start=%h", k, exp_start[k]);
      end
      seed_inc = 1'b1;
      tick();
      seed_inc = 1'b0;
      checks++;
      if (all_done !== 1'b1 || pattern_valid !== 1'b0 || seed_idx !== 2'd3) begin
         errors++;
         $display("FAIL done got done=%b v=%b idx=%0d want 1 0 3", all_done, pattern_valid, seed_idx);
      end
      tpg_reset = 1'b1;
      tick();
      tpg_reset = 1'b0;
      tick();
      checks++;
      if (all_done !== 1'b1 || pattern_valid !== 1'b0 || tpg_end !== 1'b0) begin
         errors++;
         $display("FAIL done_ignore got done=%b v=%b e=%b want 1 0 0", all_done, pattern_valid, tpg_end);
      end
      do_reset();
      checks++;
      if (pattern !== 8'h01 || all_done !== 1'b0 || seed_idx !== 2'd0 || pattern_valid !== 1'b1) begin
         errors++;
         $display("FAIL done_rst got pat=%h done=%b idx=%0d v=%b want 01 0 0 1",
                  pattern, all_done, seed_idx, pattern_valid);
      end
      $display("test_seed_inc all_done=%b", all_done);
   endtask

   task automatic test_simultaneous();
      int ends;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (pattern !== 8'h11) begin
         errors++;
         $display("FAIL simul_pre got pat=%h want 11", pattern);
      end
      seed_inc  = 1'b1;
      tpg_reset = 1'b1;
      tick();
      seed_inc  = 1'b0;
      tpg_reset = 1'b0;
      checks++;
      if (pattern !== 8'h34 || seed_idx !== 2'd1 || tpg_end !== 1'b0) begin
         errors++;
         $display("FAIL simul got pat=%h idx=%0d e=%b want 34 1 0", pattern, seed_idx, tpg_end);
      end
      ends = 0;
      for (int i = 0; i < 15; i++) begin
         if (tpg_end === 1'b1) ends++;
         tick();
      end
      checks++;
      if (ends !== 0 || tpg_end !== 1'b1) begin
         errors++;
         $display("FAIL simul_end early=%0d e16=%b want 0 1", ends, tpg_end);
      end
      $display("test_simultaneous idx=%0d", seed_idx);
   endtask

   task automatic test_mid_run_reset();
      do_reset();
      seed_inc = 1'b1;
      tick();
      tick();
      seed_inc = 1'b0;
      checks++;
      if (pattern !== 8'h6B || seed_idx !== 2'd2) begin
         errors++;
         $display("FAIL midrst_pre got pat=%h idx=%0d want 6b 2", pattern, seed_idx);
      end
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (tpg_end !== 1'b0 || pattern_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_cnt9 got e=%b v=%b want 0 1", tpg_end, pattern_valid);
      end
      do_reset();
      checks++;
      if (seed_idx !== 2'd0) begin
         errors++;
         $display("FAIL midrst idx got %0d want 0", seed_idx);
      end
      run_seed0("mid_run_rst");
   endtask

`ifdef TPG_HOLD_EN
   task automatic test_hold();
      int end_cycle;
      int vidx;
      do_reset();
      tick();
      tick();
      end_cycle = 0;
      vidx = 2;
      for (int cyc = 3; cyc <= 24; cyc++) begin
         hold = (cyc >= 3 && cyc <= 6);
         #1;
         if (hold) begin
            checks++;
            if (pattern !== 8'h04 || pattern_valid !== 1'b0 || tpg_end !== 1'b0) begin
               errors++;
               $display("FAIL hold c%0d got %h/v%b/e%b want 04/v0/e0", cyc, pattern, pattern_valid, tpg_end);
            end
         end else if (vidx < 16) begin
            checks++;
            if (pattern !== exp_seq[vidx] || pattern_valid !== 1'b1) begin
               errors++;
               $display("FAIL hold_seq c%0d got %h/v%b want %h/v1", cyc, pattern, pattern_valid, exp_seq[vidx]);
            end
            vidx++;
         end
         if (tpg_end === 1'b1 && end_cycle == 0) end_cycle = cyc;
         tick();
      end
      hold = 1'b0;
      checks++;
      if (end_cycle !== 20) begin
         errors++;
         $display("FAIL hold_end got cycle %0d want 20", end_cycle);
      end
      $display("test_hold end_cycle=%0d", end_cycle);
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      tpg_reset = 1'b0;
      seed_inc  = 1'b0;
      hold      = 1'b0;
      tick();
      test_reset();
      test_free_run();
      test_tpg_reset();
      test_seed_inc();
      test_simultaneous();
      test_mid_run_reset();
`ifdef TPG_HOLD_EN
      test_hold();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
